// File: rtl/alu_iterative.sv
// EX-stage ALU with valid/ready handshakes on both sides; shifts iterate one bit per cycle
// unless ALU_BARREL_SHIFT_EN is defined, in which case every op completes in one cycle.
module alu_iterative #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_control,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               illegal
);

`ifdef ALU_BARREL_SHIFT_EN
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  state_t state;

  // Single-cycle evaluation; MSB of the return value is the illegal flag.
  function automatic logic [WIDTH:0] eval_op(input logic [3:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    logic [SHAMT_W-1:0] amt;
    logic signed [WIDTH-1:0] sra_val;
    amt     = b[SHAMT_W-1:0];
    sra_val = $signed(a) >>> amt;
`endif
    eval_op = {1'b1, {WIDTH{1'b0}}};
    case (op)
      OP_ADD:  eval_op = {1'b0, a + b};
      OP_SUB:  eval_op = {1'b0, a - b};
      OP_AND:  eval_op = {1'b0, a & b};
      OP_OR:   eval_op = {1'b0, a | b};
      OP_XOR:  eval_op = {1'b0, a ^ b};
      OP_SLT:  eval_op = {1'b0, {(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: eval_op = {1'b0, {(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_BARREL_SHIFT_EN
      OP_SRL:  eval_op = {1'b0, a >> amt};
      OP_SLL:  eval_op = {1'b0, a << amt};
      OP_SRA:  eval_op = {1'b0, sra_val};
`else
      // Only reached with a zero shift amount; non-zero amounts go through SHIFT.
      OP_SRL, OP_SLL, OP_SRA: eval_op = {1'b0, a};
`endif
      default: eval_op = {1'b1, {WIDTH{1'b0}}};
    endcase
  endfunction

  logic [WIDTH:0] eval_out;
  assign eval_out = eval_op(alu_control, src_a, src_b);

`ifndef ALU_BARREL_SHIFT_EN
  logic [3:0]         op_reg;
  logic [SHAMT_W-1:0] count;
  logic [SHAMT_W-1:0] amt_in;
  logic               is_shift;
  logic [WIDTH-1:0]   shifted;

  assign amt_in   = src_b[SHAMT_W-1:0];
  assign is_shift = (alu_control == OP_SRL) || (alu_control == OP_SLL) ||
                    (alu_control == OP_SRA);

  // result doubles as the working register while iterating.
  always_comb begin
    shifted = {result[WIDTH-1], result[WIDTH-1:1]};
    case (op_reg)
      OP_SRL:  shifted = {1'b0, result[WIDTH-1:1]};
      OP_SLL:  shifted = {result[WIDTH-2:0], 1'b0};
      default: shifted = {result[WIDTH-1], result[WIDTH-1:1]};
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
`ifndef ALU_BARREL_SHIFT_EN
      op_reg    <= '0;
      count     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            op_reg   <= alu_control;
            if (is_shift && (amt_in != '0)) begin
              state   <= SHIFT;
              result  <= src_a;
              count   <= amt_in;
              zero    <= 1'b0;
              illegal <= 1'b0;
            end else
`endif
            begin
              state     <= DONE;
              result    <= eval_out[WIDTH-1:0];
              illegal   <= eval_out[WIDTH];
              zero      <= (eval_out[WIDTH-1:0] == '0);
              out_valid <= 1'b1;
            end
          end
        end
`ifndef ALU_BARREL_SHIFT_EN
        SHIFT: begin
          result <= shifted;
          count  <= count - SHAMT_W'(1);
          if (count == SHAMT_W'(1)) begin
            state     <= DONE;
            zero      <= (shifted == '0);
            out_valid <= 1'b1;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iterative.sv
// Directed scoreboard bench for alu_iterative: expected results are queued at request time
// and compared, together with latency, when out_valid appears.
module tb_alu_iterative;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t sb[$];

  alu_iterative #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .alu_control(alu_control),
    .src_a(src_a),
    .src_b(src_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .zero(zero),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Reference behaviour of each code, including expected latency for the build in use.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int n;
    logic signed [31:0] sa;
    n     = int'(b[4:0]);
    sa    = $signed(a) >>> n;
    e.ill = 1'b0;
    e.lat = 1;
    case (op)
      4'd0: e.res = a + b;
      4'd1: e.res = a - b;
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: e.res = a >> n;
      4'd7: e.res = a << n;
      4'd8: e.res = sa;
      4'd9: e.res = (a < b) ? 32'd1 : 32'd0;
      default: begin
        e.res = 32'd0;
        e.ill = 1'b1;
      end
    endcase
    e.zero = (e.res == 32'd0);
`ifndef ALU_BARREL_SHIFT_EN
    if ((op == 4'd6 || op == 4'd7 || op == 4'd8) && n != 0) e.lat = n + 1;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Waits (bounded) for in_ready, presents one request for one accepting edge, then scrambles inputs.
  task automatic applyStimulus(input string tag, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, ".ready_before"}, {31'd0, in_ready}, 32'd1);
    alu_control = op;
    src_a       = a;
    src_b       = b;
    in_valid    = 1'b1;
    sb.push_back(model(op, a, b));
    @(posedge clk); #1;
    in_valid    = 1'b0;
    alu_control = 4'($urandom);
    src_a       = $urandom;
    src_b       = $urandom;
    check({tag, ".ready_after"}, {31'd0, in_ready}, 32'd0);
  endtask

  // Waits (bounded) for out_valid, compares against the scoreboard head, then hands off.
  task automatic checkOutput(input string tag);
    exp_t e;
    int   lat;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    check({tag, ".latency"}, lat, e.lat);
    check({tag, ".result"}, result, e.res);
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, e.zero});
    check({tag, ".illegal"}, {31'd0, illegal}, {31'd0, e.ill});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".valid_after"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".ready_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    exp_t held;
    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    alu_control = 4'd0;
    src_a       = 32'd0;
    src_b       = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.zero", {31'd0, zero}, 32'd0);
    check("rst.illegal", {31'd0, illegal}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    applyStimulus("add", 4'b0000, 32'h5, 32'h7);               checkOutput("add");
    applyStimulus("sub_neg", 4'b0001, 32'h3, 32'h5);           checkOutput("sub_neg");
    applyStimulus("sub_zero", 4'b0001, 32'h9, 32'h9);          checkOutput("sub_zero");
    applyStimulus("and", 4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00); checkOutput("and");
    applyStimulus("or", 4'b0011, 32'hA000_0005, 32'h0500_0050);  checkOutput("or");
    applyStimulus("xor", 4'b0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF); checkOutput("xor");
    applyStimulus("sra4", 4'b1000, 32'h8000_0000, 32'd4);      checkOutput("sra4");
    applyStimulus("sll31", 4'b0111, 32'h1, 32'd31);            checkOutput("sll31");
    applyStimulus("srl0", 4'b0110, 32'h0000_00F0, 32'd0);      checkOutput("srl0");
    applyStimulus("srl7", 4'b0110, 32'h8000_0F00, 32'hFFFF_FFE7); checkOutput("srl7");
    applyStimulus("slt", 4'b0101, 32'hFFFF_FFFF, 32'h1);       checkOutput("slt");
    applyStimulus("sltu", 4'b1001, 32'hFFFF_FFFF, 32'h1);      checkOutput("sltu");
    applyStimulus("ill_f", 4'b1111, 32'h1234_5678, 32'h1);     checkOutput("ill_f");
    applyStimulus("ill_a", 4'b1010, 32'hFFFF_FFFF, 32'h0);     checkOutput("ill_a");

    // Backpressure: result must hold and new requests must be ignored while DONE waits.
    applyStimulus("hold", 4'b0000, 32'h1111_1111, 32'h2222_2222);
    held = sb.pop_front();
    check("hold.first_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      in_valid    = 1'b1;
      alu_control = 4'b0001;
      src_a       = 32'h0;
      src_b       = 32'h1;
      @(posedge clk); #1;
      check("hold.valid", {31'd0, out_valid}, 32'd1);
      check("hold.result", result, held.res);
      check("hold.in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("hold.release_valid", {31'd0, out_valid}, 32'd0);
    check("hold.release_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("hold.no_accept", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of an iterative shift abandons it.
    applyStimulus("rst_mid", 4'b0111, 32'h1, 32'd20);
    repeat (5) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    check("rst_mid.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mid.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid.result", result, 32'd0);
    check("rst_mid.zero", {31'd0, zero}, 32'd0);
    applyStimulus("post_rst", 4'b0000, 32'hFFFF_FFFF, 32'h1);  checkOutput("post_rst");

    for (int i = 0; i < 8; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 11));
      applyStimulus($sformatf("rnd%0d", i), op, $urandom, $urandom);
      checkOutput($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
